execute_muldiv_seq: RTL and testbench

Multi-cycle sequencer for RV32M multiply/divide alongside the single-cycle execute stage. It accepts one M-extension operation from decode, iterates a shift-add multiplier or restoring divider over 32 cycles, and holds the core with a stall until the registered result is ready. The result is presented to writeback in place of the ALU result for the single cycle in which `done_o` is high.

---
 rtl/execute_muldiv_seq.sv | 146 ++++++++++++++
 tb/tb_execute_muldiv_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/execute_muldiv_seq.sv
// execute_muldiv_seq
//   Multi-cycle RV32M sequencer. Accepts one multiply/divide from execute,
//   iterates a shift-add multiplier or a restoring divider for 32 cycles, and
//   stalls the core until the registered result is presented on done_o.
//
// Ports
//   clk, rst     : core clock, asynchronous active-high reset
//   start_i      : M-extension op in execute (held until done_o)
//   op_i         : funct3 (0 MUL .. 7 REMU)
//   rs1_data_i   : operand A (multiplicand / dividend)
//   rs2_data_i   : operand B (multiplier / divisor)
//   flush_i      : abort current operation
//   stall_o      : start_i & ~done_o & ~flush_i
//   busy_o       : CALC or DONE
//   done_o       : one-cycle result-valid strobe
//   result_o     : registered result, held until the next completion
module execute_muldiv_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] rs1_data_i,
  input  logic [WIDTH-1:0] rs2_data_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state, state_nxt;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   opnd_q;   // multiplicand (mul) or divisor (div) magnitude
  logic [2*WIDTH-1:0] acc_q;    // {hi/remainder, lo/multiplier/quotient}
  logic               neg_q;
  logic [5:0]         cnt;
  logic [WIDTH-1:0]   result_q;

  // Operand decode at acceptance
  logic             a_signed, b_signed, sa, sb, neg_in;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             div_zero, div_ovf, fast;
  logic [WIDTH-1:0] fast_result;

  always_comb begin
    a_signed = (op_i == 3'd1) || (op_i == 3'd2) || (op_i == 3'd4) || (op_i == 3'd6);
    b_signed = (op_i == 3'd1) || (op_i == 3'd4) || (op_i == 3'd6);
    sa       = a_signed & rs1_data_i[WIDTH-1];
    sb       = b_signed & rs2_data_i[WIDTH-1];
    // An unsigned magnitude of the most negative value is exact in WIDTH bits.
    a_mag    = sa ? -rs1_data_i : rs1_data_i;
    b_mag    = sb ? -rs2_data_i : rs2_data_i;
    // REM takes the dividend's sign; all others the xor (zero for unsigned ops).
    neg_in   = (op_i[2] & op_i[1]) ? sa : (sa ^ sb);
    div_zero = op_i[2] & (rs2_data_i == '0);
    div_ovf  = op_i[2] & ~op_i[0] & (rs1_data_i == {1'b1, {(WIDTH-1){1'b0}}})
               & (rs2_data_i == '1);
    fast     = div_zero | div_ovf;
    if (div_zero)
      fast_result = op_i[1] ? rs1_data_i : '1;
    else
      fast_result = op_i[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
  end

  // One iteration of either algorithm
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] step_nxt, prod_fin;
  logic [WIDTH-1:0]   div_word, calc_result;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ge    = div_shift >= {1'b0, opnd_q};
    if (op_q[2])
      step_nxt = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                  acc_q[WIDTH-2:0], div_ge};
    else
      step_nxt = {mul_sum, acc_q[WIDTH-1:1]};

    // Result is formed from the final step so it lands on the CALC->DONE edge.
    prod_fin = neg_q ? -step_nxt : step_nxt;
    div_word = op_q[1] ? step_nxt[2*WIDTH-1:WIDTH] : step_nxt[WIDTH-1:0];
    if (op_q[2])
      calc_result = neg_q ? -div_word : div_word;
    else if (op_q == 3'd0)
      calc_result = prod_fin[WIDTH-1:0];
    else
      calc_result = prod_fin[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = fast ? DONE : CALC;
      CALC:    if (cnt == 6'd31) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush_i) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      cnt      <= '0;
      result_q <= '0;
    end else if (!flush_i) begin
      case (state)
        IDLE: if (start_i) begin
          op_q   <= op_i;
          opnd_q <= op_i[2] ? b_mag : a_mag;
          acc_q  <= {{WIDTH{1'b0}}, (op_i[2] ? a_mag : b_mag)};
          neg_q  <= neg_in;
          cnt    <= '0;
          if (fast) result_q <= fast_result;
        end
        CALC: begin
          acc_q <= step_nxt;
          cnt   <= cnt + 6'd1;
          if (cnt == 6'd31) result_q <= calc_result;
        end
        default: ;
      endcase
    end
  end

  assign done_o   = (state == DONE);
  assign busy_o   = (state != IDLE);
  assign stall_o  = start_i & ~done_o & ~flush_i;
  assign result_o = result_q;

endmodule

// File: tb/tb_execute_muldiv_seq.sv
// Self-checking bench for execute_muldiv_seq: directed RV32M cases, flush and
// reset scenarios, then random operations against an arithmetic reference.
module tb_execute_muldiv_seq;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic        flush_i;
  logic        stall_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [31:0] last_res;

  execute_muldiv_seq #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .op_i       (op_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .flush_i    (flush_i),
    .stall_o    (stall_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .result_o   (result_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic is_fast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < 3'd4) return 1'b0;
    if (b == 32'd0) return 1'b1;
    return (op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    int          ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (op)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issue one op, hold start until done, check result, latency and stall length.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp;
    int          exp_lat, cycles, stalls;
    logic        seen;
    exp     = ref_res(op, a, b);
    exp_lat = is_fast(op, a, b) ? 1 : 33;
    @(negedge clk);
    start_i = 1'b1; op_i = op; rs1_data_i = a; rs2_data_i = b;
    #1;
    stalls = stall_o ? 1 : 0;
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
      if (done_o) seen = 1'b1;
      else if (stall_o) stalls++;
    end
    check("stall_in_done", {31'd0, stall_o}, 32'd0);
    start_i = 1'b0;
    check($sformatf("res op%0d %08h,%08h", op, a, b), result_o, exp);
    check("latency", cycles, exp_lat);
    check("stall_cycles", stalls, exp_lat);
    @(posedge clk); #1;
    check("done_one_cycle", {31'd0, done_o}, 32'd0);
    last_res = exp;
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1; start_i = 1'b0; flush_i = 1'b0;
    op_i = '0; rs1_data_i = '0; rs2_data_i = '0;
    last_res = '0;
    #12;
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_result", result_o, 32'd0);
    start_i = 1'b1; #1;
    check("rst_stall", {31'd0, stall_o}, 32'd1);
    start_i = 1'b0;
    @(negedge clk); rst = 1'b0;

    // Directed cases
    run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd5, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd5, 32'd5, 32'd0);
    run_op(3'd6, 32'd5, 32'd0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000);
    run_op(3'd4, 32'h8000_0000, 32'd1);

    // Flush at CALC cycle 10
    @(negedge clk);
    start_i = 1'b1; op_i = 3'd4; rs1_data_i = 32'd1000; rs2_data_i = 32'd3;
    repeat (11) @(posedge clk);
    @(negedge clk);
    flush_i = 1'b1; start_i = 1'b0;
    #1;
    check("flush_stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk); #1;
    check("flush_busy", {31'd0, busy_o}, 32'd0);
    check("flush_done", {31'd0, done_o}, 32'd0);
    check("flush_result", result_o, last_res);
    flush_i = 1'b0;
    run_op(3'd5, 32'd100, 32'd7);

    // flush with start in IDLE: nothing captured
    @(negedge clk);
    start_i = 1'b1; flush_i = 1'b1; op_i = 3'd5; rs1_data_i = 32'd9; rs2_data_i = 32'd0;
    @(posedge clk); #1;
    check("idle_flush_busy", {31'd0, busy_o}, 32'd0);
    check("idle_flush_done", {31'd0, done_o}, 32'd0);
    start_i = 1'b0; flush_i = 1'b0;

    // Asynchronous reset mid-CALC
    @(negedge clk);
    start_i = 1'b1; op_i = 3'd0; rs1_data_i = 32'd77; rs2_data_i = 32'd55;
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy_o}, 32'd0);
    check("arst_done", {31'd0, done_o}, 32'd0);
    check("arst_result", result_o, 32'd0);
    check("arst_stall", {31'd0, stall_o}, 32'd1);
    @(negedge clk); start_i = 1'b0; rst = 1'b0;
    run_op(3'd0, 32'd3, 32'd4);

    // Random operations
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      rop = 3'($urandom_range(0, 7));
      ra  = rnd_operand();
      rb  = rnd_operand();
      run_op(rop, ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
